tsb_bus_arbiter: RTL and testbench
==================================

Name: tsb_bus_arbiter

Overview:
- Parametrised successor to the 16-bit single-driver tri-state bus buffer.
- Lets CHANNELS requesters share one WIDTH-bit tri-state bus.
- Arbitration is round-robin, with a bounded hold time and an enforced high-Z turnaround between owners.
- Sits between the datapath sources (register file, ALU, memory interface) and the shared internal data bus.

Parameters:
- WIDTH, 16, bus and per-channel data width (1..64).
- CHANNELS, 4, number of requesters (2..16).
- TURNAROUND, 1, number of high-Z cycles forced between two ownerships (1..15).
- MAX_HOLD, 16, maximum consecutive grant cycles while another channel is waiting (2..255).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  CHANNELS  per-channel bus request, level-sensitive, held while the channel wants the bus.
- data_in  input  WIDTH*CHANNELS  per-channel drive data; channel i occupies bits [i*WIDTH +: WIDTH].
- grant  output  CHANNELS  one-hot registered grant; all zero when nobody owns the bus.
- owner_id  output  clog2(CHANNELS)  index of the current owner; valid only while bus_busy=1.
- bus_busy  output  1  high while any channel is granted.
- bus  inout  WIDTH  shared tri-state bus.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; grant=0; owner_id=0; bus_busy=0; bus=all Z.
  - Round-robin pointer=0, so channel 0 has first priority.
  - Hold and turnaround counters=0.
  - Reset mid-grant releases the bus immediately (asynchronously), with no turnaround.
- Bus drive:
  - bus = data_in slice of owner_id when bus_busy=1, else all Z.
  - The data path is combinational; the enable is registered, so there is never a glitch onto Z.
  - At most one grant bit is ever set.
- States:
  - IDLE: if any req, pick a winner by round-robin from the pointer, go to OWN, and assert grant/bus_busy on that same edge. Latency is 1 clock from req rising to grant.
  - OWN: hold counter increments each cycle. Leave OWN when either:
    - the owner's req is sampled low, or
    - hold counter = MAX_HOLD-1 while another req is pending.
    - On leaving: clear grant/bus_busy at that edge, set pointer = owner+1 (mod CHANNELS), go to TURN.
    - If no other req is pending, the owner keeps the bus indefinitely; the hold counter saturates.
  - TURN: bus is Z and grant=0 for exactly TURNAROUND cycles. On the last TURN cycle:
    - if any req, grant the round-robin winner directly (no IDLE cycle);
    - else go to IDLE.
- Round-robin: search starts at the pointer and wraps CHANNELS-1 → 0. A preempted owner still requesting is eligible again only after the other requesters in search order.
- Simultaneous events:
  - Owner drops req in the same cycle it hits MAX_HOLD: treat as a normal release (identical result).
  - req asserted during TURN is counted and can win at the end of TURN.
  - req pulses shorter than one cycle between edges are not latched.
- Preemption is enforced by the arbiter. The requester sees grant fall and must not assume further bus ownership.

Test Plan:
- Reset: rst=1 with req=4'b1111 → grant=0, bus_busy=0, bus=16'hzzzz; release rst, next edge → grant=4'b0001, bus=data_in[15:0].
- Single requester: req[2]=1 for 5 cycles with data 16'hA5A5 → grant=4'b0100 from cycle 1 for 5 cycles, bus=16'hA5A5; req[2] low → grant=0, then 1 Z cycle (TURNAROUND=1), then IDLE.
- Round robin: req=4'b1011 held, each owner drops req after 3 cycles and re-raises it → ownership order 0,1,3,0, each separated by exactly 1 Z cycle; grant never has two bits set.
- Max hold: req[1] held continuously, req[3] rises at cycle 4 → channel 1 preempted after 16 grant cycles, 1 Z cycle, grant=4'b1000, owner_id=3.
- Hold without contention: only req[0] held for 40 cycles → grant=4'b0001 for all 40 cycles, no preemption.
- Async reset mid-grant: channel 3 owning, rst pulsed between clock edges → grant=0 and bus=Z immediately (before the next edge); after release, priority restarts at channel 0.

Source files
------------

// File: rtl/tsb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tsb_bus_arbiter
// Purpose  : Round-robin arbiter driving one shared tri-state bus from
//            CHANNELS requesters, with bounded hold time and a forced
//            high-Z turnaround between successive owners.
// Revision : 1.0 - initial release
// ============================================================================
module tsb_bus_arbiter #(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS-1:0]                 req,
    input  logic [WIDTH*CHANNELS-1:0]           data_in,
    output logic [CHANNELS-1:0]                 grant,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] owner_id,
    output logic                                bus_busy,
    inout  wire  [WIDTH-1:0]                    bus
);

    localparam int IDW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Last value of the hold / turnaround counters before action is taken.
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] c_TURN_LAST = 4'(TURNAROUND - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t                r_state,  w_nxt_state;
    logic [CHANNELS-1:0]   r_grant,  w_nxt_grant;
    logic [IDW-1:0]        r_owner,  w_nxt_owner;
    logic                  r_busy,   w_nxt_busy;
    logic [IDW-1:0]        r_ptr,    w_nxt_ptr;
    logic [7:0]            r_hold,   w_nxt_hold;
    logic [3:0]            r_turn,   w_nxt_turn;

    logic                  w_found;
    logic [IDW-1:0]        w_win;
    logic [CHANNELS-1:0]   w_win_oh;
    logic [IDW-1:0]        w_cand;
    int                    w_idx;
    logic [IDW-1:0]        w_ptr_inc;
    logic                  w_owner_req;
    logic                  w_others_req;
    logic [WIDTH-1:0]      w_drive;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_win_oh = '0;
        w_idx    = 0;
        w_cand   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= CHANNELS) begin
                w_idx = w_idx - CHANNELS;
            end
            w_cand = w_idx[IDW-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        w_win_oh[w_win] = w_found;
    end

    // Pointer for the next search: the slot just after the outgoing owner,
    // which places a preempted owner last in the search order.
    assign w_ptr_inc    = (r_owner == IDW'(CHANNELS - 1)) ? '0 : r_owner + 1'b1;
    assign w_owner_req  = |(req & r_grant);
    assign w_others_req = |(req & ~r_grant);

    // Data mux selects the owner's slice; only the enable is registered.
    always_comb begin
        w_drive = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_owner == IDW'(i)) begin
                w_drive = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus      = r_busy ? w_drive : {WIDTH{1'bz}};
    assign grant    = r_grant;
    assign owner_id = r_owner;
    assign bus_busy = r_busy;

    // Next-state and next-output decode for the arbitration FSM.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_owner = r_owner;
        w_nxt_busy  = r_busy;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold;
        w_nxt_turn  = r_turn;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_nxt_state = ST_OWN;
                    w_nxt_grant = w_win_oh;
                    w_nxt_owner = w_win;
                    w_nxt_busy  = 1'b1;
                    w_nxt_hold  = '0;
                end
            end
            ST_OWN: begin
                // A release and a hold-limit hit in the same cycle both land here.
                if (!w_owner_req || ((r_hold == c_HOLD_LAST) && w_others_req)) begin
                    w_nxt_state = ST_TURN;
                    w_nxt_grant = '0;
                    w_nxt_busy  = 1'b0;
                    w_nxt_ptr   = w_ptr_inc;
                    w_nxt_turn  = '0;
                end else if (r_hold != c_HOLD_LAST) begin
                    w_nxt_hold = r_hold + 8'd1;
                end
            end
            ST_TURN: begin
                if (r_turn == c_TURN_LAST) begin
                    if (w_found) begin
                        w_nxt_state = ST_OWN;
                        w_nxt_grant = w_win_oh;
                        w_nxt_owner = w_win;
                        w_nxt_busy  = 1'b1;
                        w_nxt_hold  = '0;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    w_nxt_turn = r_turn + 4'd1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = '0;
                w_nxt_busy  = 1'b0;
            end
        endcase
    end

    // State register; reset drops the bus enable at once, with no turnaround.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_turn  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_owner <= w_nxt_owner;
            r_busy  <= w_nxt_busy;
            r_ptr   <= w_nxt_ptr;
            r_hold  <= w_nxt_hold;
            r_turn  <= w_nxt_turn;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tsb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tsb_bus_arbiter
// Purpose  : Directed self-checking bench for tsb_bus_arbiter (default
//            parameters). Expected outputs are queued with each stimulus
//            step and popped after the clock edge that produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tsb_bus_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic       b;
        logic [1:0] o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] data_in;
    wire  [3:0]  grant;
    wire  [1:0]  owner_id;
    wire         bus_busy;
    wire  [15:0] bus;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        q[$];
    logic [15:0] dat[4];

    tsb_bus_arbiter #(
        .WIDTH      (16),
        .CHANNELS   (4),
        .TURNAROUND (1),
        .MAX_HOLD   (16)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .owner_id (owner_id),
        .bus_busy (bus_busy),
        .bus      (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [3:0] g, input logic b, input logic [1:0] o);
        exp_t e;
        e.g = g;
        e.b = b;
        e.o = o;
        q.push_back(e);
    endtask

    task automatic chk(input string tag);
        exp_t        e;
        logic [15:0] ebus;
        n_checks++;
        assert (q.size() != 0) else begin
            n_errors++;
            $error("FAIL %s: scoreboard empty, observed grant %b", tag, grant);
        end
        if (q.size() != 0) begin
            e    = q.pop_front();
            ebus = e.b ? dat[e.o] : 16'hzzzz;
            n_checks++;
            assert (grant === e.g) else begin
                n_errors++;
                $error("FAIL %s grant: observed %b expected %b", tag, grant, e.g);
            end
            n_checks++;
            assert (bus_busy === e.b) else begin
                n_errors++;
                $error("FAIL %s bus_busy: observed %b expected %b", tag, bus_busy, e.b);
            end
            if (e.b) begin
                n_checks++;
                assert (owner_id === e.o) else begin
                    n_errors++;
                    $error("FAIL %s owner_id: observed %0d expected %0d", tag, owner_id, e.o);
                end
            end
            n_checks++;
            assert (bus === ebus) else begin
                n_errors++;
                $error("FAIL %s bus: observed %h expected %h", tag, bus, ebus);
            end
            n_checks++;
            assert ($onehot0(grant)) else begin
                n_errors++;
                $error("FAIL %s onehot: observed grant %b expected at most one bit", tag, grant);
            end
        end
    endtask

    // Drive req for one cycle, queue the expected post-edge outputs, check them.
    task automatic cyc(input logic [3:0] r, input logic [3:0] g, input logic b,
                       input logic [1:0] o, input string tag);
        req = r;
        push_exp(g, b, o);
        @(posedge clk);
        #1;
        chk(tag);
    endtask

    // Reset pulse placed between clock edges; the bus must release at once.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        push_exp(4'b0000, 1'b0, 2'd0);
        #1;
        chk(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        dat[0]  = 16'h1111;
        dat[1]  = 16'h2222;
        dat[2]  = 16'hA5A5;
        dat[3]  = 16'h3C3C;
        data_in = {dat[3], dat[2], dat[1], dat[0]};
        rst     = 1'b1;
        req     = 4'b1111;

        // Reset holds everything off even with all requests high
        @(posedge clk);
        #1;
        push_exp(4'b0000, 1'b0, 2'd0);
        chk("reset");
        rst = 1'b0;
        cyc(4'b1111, 4'b0001, 1'b1, 2'd0, "first_grant");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "first_release");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "first_turn");

        // Single requester on channel 2 for five cycles
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0100, 4'b0100, 1'b1, 2'd2, "single_own");
        end
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "single_release");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "single_turn");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "single_idle");

        // Round robin 0,1,3,0 starting from a fresh pointer
        async_reset("rr_reset");
        for (int i = 0; i < 3; i++) cyc(4'b1011, 4'b0001, 1'b1, 2'd0, "rr_own0");
        cyc(4'b1010, 4'b0000, 1'b0, 2'd0, "rr_turn0");
        for (int i = 0; i < 3; i++) cyc(4'b1011, 4'b0010, 1'b1, 2'd1, "rr_own1");
        cyc(4'b1001, 4'b0000, 1'b0, 2'd0, "rr_turn1");
        for (int i = 0; i < 3; i++) cyc(4'b1011, 4'b1000, 1'b1, 2'd3, "rr_own3");
        cyc(4'b0011, 4'b0000, 1'b0, 2'd0, "rr_turn3");
        cyc(4'b1011, 4'b0001, 1'b1, 2'd0, "rr_own0_again");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "rr_release");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "rr_idle");

        // Max hold: channel 1 preempted after 16 grant cycles by channel 3
        for (int i = 0; i < 3; i++) cyc(4'b0010, 4'b0010, 1'b1, 2'd1, "hold_alone");
        for (int i = 0; i < 13; i++) cyc(4'b1010, 4'b0010, 1'b1, 2'd1, "hold_contended");
        cyc(4'b1010, 4'b0000, 1'b0, 2'd0, "hold_preempt");
        cyc(4'b1010, 4'b1000, 1'b1, 2'd3, "hold_new_owner");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "hold_release");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "hold_idle");

        // No contention: channel 0 keeps the bus well past MAX_HOLD
        for (int i = 0; i < 40; i++) cyc(4'b0001, 4'b0001, 1'b1, 2'd0, "nocontend_own");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "nocontend_release");
        cyc(4'b0000, 4'b0000, 1'b0, 2'd0, "nocontend_idle");

        // Async reset while channel 3 owns the bus
        cyc(4'b1000, 4'b1000, 1'b1, 2'd3, "areset_own3");
        cyc(4'b1000, 4'b1000, 1'b1, 2'd3, "areset_own3_hold");
        async_reset("areset_release");
        cyc(4'b1001, 4'b0001, 1'b1, 2'd0, "areset_priority0");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
